// File: rtl/spi_pkg.sv
// Shared types and constant helpers for the SPI register slave.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  // Read/write flag sits in the MSB of the command word.
  function automatic int unsigned cmd_rw_bit(int unsigned data_w);
    return data_w - 1;
  endfunction

  // Leading SCLK edge is rising when the idle level is low.
  function automatic bit lead_is_rise(int cpol);
    return (cpol == 0);
  endfunction

  // Sampling happens on the leading edge for CPHA=0, trailing for CPHA=1,
  // so the sample edge is rising exactly when CPOL and CPHA agree.
  function automatic bit sample_on_rise(int cpol, int cpha);
    return lead_is_rise(cpol) == (cpha == 0);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser followed by an edge register producing registered
// rise/fall strobes; level is taken from the edge stage so data sampled with
// it lines up with the strobes of sibling instances.
module spi_sync_edge #(
  parameter bit EDGES = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] pipe;

  assign level = pipe[2];

  // Synchronise the pin and register single-cycle edge strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      pipe <= {pipe[1:0], din};
      rise <= EDGES & pipe[1] & ~pipe[2];
      fall <= EDGES & ~pipe[1] & pipe[2];
    end
  end

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave giving register-level access: a command word (R/W flag plus
// start address) followed by auto-incrementing data words.
module spi_reg_slave
  import spi_pkg::*;
#(
  parameter int  DATA_W   = 8,
  parameter int  NUM_REGS = 16,
  parameter int  CPOL     = 0,
  parameter int  CPHA     = 0,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              SSEL,
  input  logic              MOSI,
  output logic              MISO,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [7:0]        word_cnt
);

  localparam bit                 SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam int unsigned        RW_BIT      = cmd_rw_bit(DATA_W);
  localparam int                 CNT_W       = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]   LAST_BIT    = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(NUM_REGS - 1);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic ssel_rise, ssel_fall, ssel_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  state_t              state, state_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   rx_shift, rx_word;
  logic [DATA_W-1:0]   tx_shift, tx_next;
  logic [ADDR_W-1:0]   addr, addr_inc;
  logic                is_read;
  logic                load_pending;
  logic                in_frame;
  logic                sample_edge, shift_edge;
  logic                word_done;

  spi_sync_edge #(.EDGES(1'b1)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (SCLK),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.EDGES(1'b1)) u_ssel_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (SSEL),
    .level (ssel_level_unused),
    .rise  (ssel_rise),
    .fall  (ssel_fall)
  );

  spi_sync_edge #(.EDGES(1'b0)) u_mosi_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (MOSI),
    .level (mosi_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign in_frame    = (state != IDLE);
  assign busy        = in_frame;
  assign rx_word     = {rx_shift[DATA_W-2:0], mosi_s};
  assign addr_inc    = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
  assign word_done   = in_frame && !ssel_rise && sample_edge && (bit_cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; SSEL release wins over any other transition.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (ssel_fall) state_next = CMD;
      CMD:     if (word_done) state_next = DATA;
      DATA:    state_next = DATA;
      default: state_next = IDLE;
    endcase
    if (ssel_rise) state_next = IDLE;
  end

  // Transmit shifter next value: cleared when idle, reloaded from the
  // register file on the first shift edge after a read word boundary.
  always_comb begin
    tx_next = tx_shift;
    if (state == IDLE) begin
      tx_next = '0;
    end else if (shift_edge) begin
      tx_next = load_pending ? rd_data : {tx_shift[DATA_W-2:0], 1'b0};
    end
  end

  // Receive/transmit shifting, address sequencing and register-file strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      MISO         <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      rd_addr      <= '0;
      word_cnt     <= '0;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      addr         <= '0;
      is_read      <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      tx_shift <= tx_next;
      MISO     <= (state_next == IDLE) ? 1'b0 : tx_next[DATA_W-1];
      if (state == IDLE) begin
        if (ssel_fall) begin
          bit_cnt      <= '0;
          rx_shift     <= '0;
          word_cnt     <= '0;
          is_read      <= 1'b0;
          load_pending <= 1'b0;
        end
      end else if (!ssel_rise) begin
        if (sample_edge) begin
          rx_shift <= rx_word;
          bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
        if (word_done) begin
          if (word_cnt != 8'hFF) word_cnt <= word_cnt + 8'd1;
          if (state == CMD) begin
            addr    <= rx_word[ADDR_W-1:0];
            is_read <= rx_word[RW_BIT];
            if (rx_word[RW_BIT]) begin
              rd_addr      <= rx_word[ADDR_W-1:0];
              load_pending <= 1'b1;
            end
          end else if (is_read) begin
            rd_addr      <= addr;
            load_pending <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= rx_word;
            addr    <= addr_inc;
          end
        end
        if (shift_edge && load_pending) begin
          load_pending <= 1'b0;
          addr         <= addr_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: four 8-bit instances (SPI modes 0-3) and one
// 16-bit/32-register instance, driven by a bit-banged SPI master.
module tb_spi_reg_slave;

  localparam int H = 8;  // clk cycles per SCLK half period

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] sclk, ssel, mosi, miso;

  logic [3:0]       wr_en8, busy8;
  logic [3:0][3:0]  wr_addr8, rd_addr8;
  logic [3:0][7:0]  wr_data8, rd_data8, word_cnt8;

  logic        wr_en16, busy16;
  logic [4:0]  wr_addr16, rd_addr16;
  logic [15:0] wr_data16, rd_data16;
  logic [7:0]  word_cnt16;

  logic [7:0]  regs8  [16];
  logic [15:0] regs16 [32];

  typedef struct {
    int inst;
    int addr;
    int data;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] mq[$];
  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_reg_slave #(.DATA_W(8), .NUM_REGS(16), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .SCLK     (sclk[g]),
      .SSEL     (ssel[g]),
      .MOSI     (mosi[g]),
      .MISO     (miso[g]),
      .wr_en    (wr_en8[g]),
      .wr_addr  (wr_addr8[g]),
      .wr_data  (wr_data8[g]),
      .rd_addr  (rd_addr8[g]),
      .rd_data  (rd_data8[g]),
      .busy     (busy8[g]),
      .word_cnt (word_cnt8[g])
    );
  end

  spi_reg_slave #(.DATA_W(16), .NUM_REGS(32), .CPOL(0), .CPHA(0)) u_dut16 (
    .clk      (clk),
    .rst      (rst),
    .SCLK     (sclk[4]),
    .SSEL     (ssel[4]),
    .MOSI     (mosi[4]),
    .MISO     (miso[4]),
    .wr_en    (wr_en16),
    .wr_addr  (wr_addr16),
    .wr_data  (wr_data16),
    .rd_addr  (rd_addr16),
    .rd_data  (rd_data16),
    .busy     (busy16),
    .word_cnt (word_cnt16)
  );

  // Register file model: data valid one clk after the address.
  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) rd_data8[g] <= regs8[rd_addr8[g]];
    rd_data16 <= regs16[rd_addr16];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input int inst, input int addr, input int data);
    wr_t e;
    e.inst = inst;
    e.addr = addr;
    e.data = data;
    wq.push_back(e);
  endtask

  task automatic got_wr(input int inst, input int addr, input int data);
    wr_t e;
    check("wr_expected", wq.size() != 0, 1);
    if (wq.size() != 0) begin
      e = wq.pop_front();
      check("wr_inst", inst, e.inst);
      check("wr_addr", addr, e.addr);
      check("wr_data", data, e.data);
    end
  endtask

  // Write-strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 4; g++)
        if (wr_en8[g]) got_wr(g, int'(wr_addr8[g]), int'(wr_data8[g]));
      if (wr_en16) got_wr(4, int'(wr_addr16), int'(wr_data16));
    end
  end

  function automatic logic mode_cpol(input int inst);
    return (inst == 2) || (inst == 3);
  endfunction

  function automatic logic mode_cpha(input int inst);
    return (inst == 1) || (inst == 3);
  endfunction

  task automatic half();
    repeat (H) @(negedge clk);
  endtask

  task automatic frame_start(input int inst);
    sclk[inst] = mode_cpol(inst);
    ssel[inst] = 1'b0;
    half();
  endtask

  task automatic frame_end(input int inst);
    half();
    ssel[inst] = 1'b1;
    half();
    half();
  endtask

  // Bit-banged master: shifts out nbits of data MSB first, captures MISO
  // on each sample edge.
  task automatic xfer(input int inst, input int w, input logic [15:0] data,
                      input int nbits, output logic [15:0] rx);
    logic cpol, cpha;
    cpol = mode_cpol(inst);
    cpha = mode_cpha(inst);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi[inst] = data[w-1-i];
        half();
        rx = {rx[14:0], miso[inst]};
        sclk[inst] = ~cpol;
        half();
        sclk[inst] = cpol;
      end else begin
        sclk[inst] = ~cpol;
        mosi[inst] = data[w-1-i];
        half();
        rx = {rx[14:0], miso[inst]};
        sclk[inst] = cpol;
        half();
      end
    end
  endtask

  task automatic word(input int inst, input int w, input logic [15:0] data, input logic [15:0] exp_miso);
    logic [15:0] rx;
    mq.push_back(exp_miso);
    xfer(inst, w, data, w, rx);
    check($sformatf("miso_i%0d", inst), rx, mq.pop_front());
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"},     miso[0],      0);
    check({tag, "_wr_en"},    wr_en8[0],    0);
    check({tag, "_wr_addr"},  wr_addr8[0],  0);
    check({tag, "_wr_data"},  wr_data8[0],  0);
    check({tag, "_rd_addr"},  rd_addr8[0],  0);
    check({tag, "_busy"},     busy8[0],     0);
    check({tag, "_word_cnt"}, word_cnt8[0], 0);
  endtask

  initial begin
    logic [15:0] rx;
    rst  = 1'b1;
    sclk = 5'b01100;
    ssel = '1;
    mosi = '0;
    for (int i = 0; i < 16; i++) regs8[i] = 8'(i * 7 + 3);
    regs8[15] = 8'h11;
    regs8[0]  = 8'h22;
    for (int i = 0; i < 32; i++) regs16[i] = '0;

    repeat (4) @(negedge clk);
    check_reset_vals("reset");
    check("reset_busy16", busy16, 0);
    check("reset_miso16", miso[4], 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Write and read frames in each SPI mode.
    for (int m = 0; m < 4; m++) begin
      push_wr(m, 3, 'hA5);
      push_wr(m, 4, 'h5A);
      frame_start(m);
      word(m, 8, 16'h03, 16'h00);
      check($sformatf("busy_i%0d", m), busy8[m], 1);
      word(m, 8, 16'hA5, 16'h00);
      word(m, 8, 16'h5A, 16'h00);
      check($sformatf("word_cnt_i%0d", m), word_cnt8[m], 3);
      frame_end(m);
      check($sformatf("busy_end_i%0d", m), busy8[m], 0);

      frame_start(m);
      word(m, 8, 16'h8F, 16'h00);
      check($sformatf("rd_addr_cmd_i%0d", m), rd_addr8[m], 15);
      word(m, 8, 16'h00, 16'h11);
      check($sformatf("rd_addr_wrap_i%0d", m), rd_addr8[m], 0);
      word(m, 8, 16'h00, 16'h22);
      frame_end(m);
    end

    // Abort mid-word, then a clean frame.
    frame_start(0);
    word(0, 8, 16'h02, 16'h00);
    xfer(0, 8, 16'hFF, 5, rx);
    frame_end(0);
    check("abort_busy", busy8[0], 0);
    push_wr(0, 6, 'h3C);
    frame_start(0);
    word(0, 8, 16'h06, 16'h00);
    word(0, 8, 16'h3C, 16'h00);
    frame_end(0);

    // Reset during bit 3 of a data word with SSEL held low.
    frame_start(0);
    word(0, 8, 16'h01, 16'h00);
    xfer(0, 8, 16'hC3, 3, rx);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    xfer(0, 8, 16'h18, 5, rx);
    word(0, 8, 16'h77, 16'h00);
    check("midrst_busy", busy8[0], 0);
    check("midrst_word_cnt", word_cnt8[0], 0);
    frame_end(0);
    push_wr(0, 7, 'h99);
    frame_start(0);
    word(0, 8, 16'h07, 16'h00);
    word(0, 8, 16'h99, 16'h00);
    frame_end(0);

    // 16-bit words with a 32-entry address space.
    push_wr(4, 31, 'hBEEF);
    push_wr(4, 0, 'h1234);
    frame_start(4);
    word(4, 16, 16'h001F, 16'h0000);
    word(4, 16, 16'hBEEF, 16'h0000);
    word(4, 16, 16'h1234, 16'h0000);
    check("word_cnt16", word_cnt16, 3);
    frame_end(4);

    repeat (20) @(negedge clk);
    check("wr_left", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

Parametrised SPI slave giving the host register-level access to the demo's parameter registers. SCLK, SSEL and MOSI are oversampled in the system clock domain, and all four SPI modes are supported. Each frame is a command word followed by data words with auto-incrementing addresses. The block sits between the chip's SPI pins and the parameter register file: it emits write strobes and returns register contents on MISO.

## Interface
Parameters:
- DATA_W, 8, SPI word width in bits; must be ≥ ADDR_W+1
- NUM_REGS, 16, number of addressable registers; ADDR_W = clog2(NUM_REGS)
- CPOL, 0, SCLK idle level
- CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge

Ports:
- clk  in  1  system clock; must run at ≥ 4× SCLK
- rst  in  1  synchronous reset, active-high
- SCLK  in  1  SPI clock, asynchronous to clk
- SSEL  in  1  chip select, active-low, asynchronous
- MOSI  in  1  serial data in, MSB first
- MISO  out  1  serial data out, MSB first; driven 0 when idle (no tristate)
- wr_en  out  1  one-clk write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- rd_addr  out  ADDR_W  read address to the register file
- rd_data  in  DATA_W  register-file data; valid one clk after rd_addr
- busy  out  1  frame in progress
- word_cnt  out  8  number of complete words in the current frame; saturates at 255

## Operation
- **Synchronisation:** SCLK, SSEL and MOSI each pass through two flops. SCLK and SSEL are then edge-detected. Leading and trailing edges are resolved from CPOL. Sample and shift edges are resolved from CPHA.
- **State machine:** IDLE → CMD on the synchronised falling edge of SSEL. CMD → DATA when DATA_W bits have been sampled. A rising edge of SSEL from any state returns to IDLE.
- **Command word:** bit DATA_W-1 is 1 for read and 0 for write. Bits ADDR_W-1:0 give the start address. All other bits are ignored.
- **Receive path:** MOSI is shifted into rx_shift on each sample edge. The bit counter wraps at DATA_W-1 and marks the word complete. word_cnt increments on each complete word.
- **Write frame:** each complete DATA word pulses wr_en for 1 clk with wr_data = rx word and wr_addr = current address. The address then increments.
- **Read frame:** rd_addr is driven with the current address when each word completes (including the command word). A load_pending flag is set at the same point. On the next shift edge, tx_shift loads rd_data instead of shifting, and the address increments. On every other shift edge in DATA, tx_shift shifts left. MISO = tx_shift MSB.
- **Address wrap:** the address wraps from NUM_REGS-1 to 0.
- **MISO in CMD and write frames:** MISO is 0 during CMD and throughout write frames. tx_shift is cleared at the SSEL falling edge.
- **SSEL deasserted mid-word:** the partial word is discarded. There is no wr_en and no address change.
- **SSEL falling and rising in the same synchronised sample:** impossible once synchronised; no special handling is needed.
- **SSEL low at reset release:** the frame is ignored. The FSM stays in IDLE until a fresh falling edge of SSEL.

## Timing
- **Reset values:** MISO=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, word_cnt=0, FSM=IDLE, all shift registers and counters 0.
- **Input latency:** 3 clk from a pin transition to the corresponding internal edge strobe (2 sync flops plus edge register).
- **Write latency:** wr_en asserts 1 clk after the internal sample edge of a word's last bit.
- **Read data timing:** rd_data is captured 1 clk after rd_addr changes. It is used at the next shift edge, which is ≥ 2 clk later given clk ≥ 4× SCLK.
- **MISO output:** MISO is registered and updates 1 clk after the internal shift edge.
- **busy:** asserts 1 clk after the internal SSEL falling edge and deasserts 1 clk after the internal SSEL rising edge.
- **word_cnt:** cleared at the SSEL falling edge.

## Structure
- **Package spi_pkg:** FSM state enum (IDLE, CMD, DATA), the CMD_RW_BIT position, and edge-select helper constants derived from CPOL/CPHA.
- **Sub-module spi_sync_edge:** 2-FF synchroniser with optional rise/fall strobe outputs. It is instantiated for SCLK and SSEL, and for MOSI with the edge outputs unused.
- The FSM, shift registers and address counter live in spi_reg_slave.

## Test plan
- **Mode 0 write, DATA_W=8:** command 0x03, data 0xA5 and 0x5A → wr_en pulses at addr 3 (0xA5) and addr 4 (0x5A); word_cnt=3; MISO stays 0.
- **Mode 3 read:** command 0x8F with register file holding reg15=0x11 and reg0=0x22; clock 2 data words → MISO returns 0x11 then 0x22 (address wraps); rd_addr sequence 15, 0.
- **Modes 1 and 2:** repeat the write and read scenarios → identical wr_en, wr_addr, wr_data and MISO word values to mode 0.
- **Abort:** command 0x02, then SSEL rises after 5 bits of the data word → no wr_en; busy drops; the next frame's command is decoded correctly.
- **Reset mid-frame:** assert rst during bit 3 of a data word while SSEL stays low → all outputs at reset values; later data bits are ignored until SSEL rises and falls again.
- **Generalised width, DATA_W=16, NUM_REGS=32:** command 0x001F, write data 0xBEEF → wr_addr=31, wr_data=0xBEEF; next word writes at addr 0.
